lane_width_striper: RTL

- Parametrised successor to byte_striper: stripes a packet byte stream across a run-time-selectable number of active lanes (x1, x2, x4 … NUM_LANES), following PCIe byte-striping order.
- Pads the final partial symbol time with PAD symbols and flags them as K-codes.
- Elastic byte buffer with valid/ready on both sides decouples input word width from active lane count.
- Sits between the TLP/DLLP framer and the per-lane scramblers/encoders.

---
 rtl/lane_width_striper.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/lane_width_striper.sv
`default_nettype none
// ============================================================================
// Module   : lane_width_striper
// Purpose  : Stripes a packet byte stream across 1..NUM_LANES active lanes in
//            PCIe byte-striping order. The final partial symbol time is
//            padded with PAD_SYM K-codes. An elastic byte buffer with
//            valid/ready on both sides decouples the input word width from
//            the active lane count.
// Revision : 1.0 - initial release
// ============================================================================
module lane_width_striper #(
  parameter int         NUM_LANES = 4,
  parameter int         IN_BYTES  = 4,
  parameter logic [7:0] PAD_SYM   = 8'hF7
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [$clog2(NUM_LANES):0]   cfg_width,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [IN_BYTES*8-1:0]        in_data,
  input  logic [$clog2(IN_BYTES):0]    in_nbytes,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_LANES*8-1:0]       out_data,
  output logic [NUM_LANES-1:0]         out_k,
  output logic [NUM_LANES-1:0]         out_lane_en,
  output logic                         out_last,
  output logic                         busy
);

  localparam int LOG_LANES = $clog2(NUM_LANES);
  localparam int MAX_W     = (IN_BYTES > NUM_LANES) ? IN_BYTES : NUM_LANES;
  localparam int BUF       = 2 * MAX_W;
  localparam int CNT_W     = $clog2(BUF + 1);
  localparam int WID_W     = LOG_LANES + 1;
  // The view covers the buffer plus one lane-width of slack so the pop
  // shift never indexes outside it.
  localparam int VIEW      = BUF + MAX_W;
  localparam int VIEW_IW   = $clog2(VIEW);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [7:0]             buf_q [BUF];
  logic [7:0]             buf_d [BUF];
  logic [WID_W-1:0]       width_q, width_d;
  logic                   out_valid_q, out_valid_d;
  logic [NUM_LANES*8-1:0] out_data_q, out_data_d;
  logic [NUM_LANES-1:0]   out_k_q, out_k_d;
  logic                   out_last_q, out_last_d;

  logic                   push;
  logic                   out_hs;
  logic                   flush_now;
  logic                   load;
  logic [WID_W-1:0]       cfg_lanes;
  logic [WID_W-1:0]       cur_width;
  logic [7:0]             view [VIEW];
  logic [VIEW_IW-1:0]     wr_idx;
  logic [VIEW_IW-1:0]     rd_idx;
  int                     tot_bytes;
  int                     lanes;
  int                     pop_bytes;

  // Accept only when a full input word is guaranteed to fit; never while
  // the reset pin is asserted and never while the packet tail drains.
  assign in_ready = rst && (state_q != FLUSH) && (int'(cnt_q) <= BUF - IN_BYTES);
  assign push     = in_valid && in_ready;
  assign out_hs   = out_valid_q && out_ready;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_k     = out_k_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != IDLE);

  // Clamp the requested width and pick the width in force this cycle: the
  // first beat in IDLE uses the fresh config, everything else the latch.
  always_comb begin
    if (int'(cfg_width) > LOG_LANES) begin
      cfg_lanes = WID_W'(NUM_LANES);
    end else begin
      cfg_lanes = WID_W'(1) << cfg_width;
    end
    cur_width = (state_q == IDLE) ? cfg_lanes : width_q;
    width_d   = (state_q == IDLE && push) ? cfg_lanes : width_q;
  end

  // Active-lane mask follows the latched width (x1 out of reset).
  always_comb begin
    out_lane_en = '0;
    for (int j = 0; j < NUM_LANES; j++) begin
      out_lane_en[j] = (j < int'(width_q));
    end
  end

  // Next-state logic for the packet FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (push) begin
          state_d = in_last ? FLUSH : STREAM;
        end
      end
      STREAM: begin
        if (push && in_last) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (out_hs && out_last_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Byte view = buffered bytes followed by this cycle's pushed bytes, so a
  // beat can reach the output register on the same edge it is accepted.
  always_comb begin
    for (int i = 0; i < VIEW; i++) begin
      view[i] = 8'h00;
    end
    for (int i = 0; i < BUF; i++) begin
      view[i] = buf_q[i];
    end
    wr_idx = '0;
    if (push) begin
      for (int b = 0; b < IN_BYTES; b++) begin
        if (b < int'(in_nbytes)) begin
          wr_idx       = VIEW_IW'(int'(cnt_q) + b);
          view[wr_idx] = in_data[b*8 +: 8];
        end
      end
    end
  end

  // Symbol formation, output register load/hold and buffer compaction.
  always_comb begin
    tot_bytes = int'(cnt_q) + (push ? int'(in_nbytes) : 0);
    lanes     = int'(cur_width);
    // The tail may go out short only once the last beat is in.
    flush_now = (state_q == FLUSH) || (push && in_last);
    load      = ((tot_bytes >= lanes) || (flush_now && tot_bytes > 0)) &&
                (!out_valid_q || out_ready);
    pop_bytes = 0;

    out_valid_d = out_hs ? 1'b0 : out_valid_q;
    out_last_d  = out_hs ? 1'b0 : out_last_q;
    out_data_d  = out_data_q;
    out_k_d     = out_k_q;

    if (load) begin
      pop_bytes   = (tot_bytes < lanes) ? tot_bytes : lanes;
      out_valid_d = 1'b1;
      out_last_d  = flush_now && (tot_bytes <= lanes);
      for (int j = 0; j < NUM_LANES; j++) begin
        if (j >= lanes) begin
          out_data_d[j*8 +: 8] = 8'h00;
          out_k_d[j]           = 1'b0;
        end else if (j < tot_bytes) begin
          out_data_d[j*8 +: 8] = view[j];
          out_k_d[j]           = 1'b0;
        end else begin
          out_data_d[j*8 +: 8] = PAD_SYM;
          out_k_d[j]           = 1'b1;
        end
      end
    end

    // Shift the remaining bytes down so buffer byte 0 is always the oldest.
    rd_idx = '0;
    for (int i = 0; i < BUF; i++) begin
      rd_idx   = VIEW_IW'(i + pop_bytes);
      buf_d[i] = view[rd_idx];
    end
    cnt_d = CNT_W'(tot_bytes - pop_bytes);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Buffer, latched width and output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      width_q     <= WID_W'(1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_k_q     <= '0;
      out_last_q  <= 1'b0;
      for (int i = 0; i < BUF; i++) begin
        buf_q[i] <= 8'h00;
      end
    end else begin
      cnt_q       <= cnt_d;
      width_q     <= width_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_k_q     <= out_k_d;
      out_last_q  <= out_last_d;
      for (int i = 0; i < BUF; i++) begin
        buf_q[i] <= buf_d[i];
      end
    end
  end

endmodule
`default_nettype wire
